exe_unit_scheduler: RTL and testbench

Issue and writeback controller for the execute stage. Accepts one decoded instruction per cycle from register read and launches it on the ALU or on one of the multi-cycle units (MUL, DIV, MEM). It tracks outstanding multi-cycle operations in a destination-register scoreboard. It also merges all unit completions onto a single registered writeback port under fixed priority.

---
 rtl/drac_pkg.sv | 31 +++
 rtl/exe_sched_slot.sv | 70 +++++++
 rtl/exe_unit_scheduler.sv | 149 ++++++++++++++
 tb/tb_exe_unit_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared execute-stage types: unit encoding, writeback bundle
// and the fixed drain priority for the long-latency units.
package drac_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2,
    UNIT_MEM = 2'd3
  } exe_unit_t;

  localparam int EXE_RD_W     = 5;
  localparam int EXE_DATA_W   = 64;
  localparam int EXE_NUM_LONG = 3;

  typedef struct packed {
    logic                  valid;
    logic [EXE_RD_W-1:0]   rd;
    logic [EXE_DATA_W-1:0] data;
  } exe_sched_wb_t;

  // Highest priority first.
  localparam exe_unit_t EXE_DRAIN_PRIO [EXE_NUM_LONG] =
    '{UNIT_MEM, UNIT_MUL, UNIT_DIV};

  // Long units map onto slots 0..2 (MUL, DIV, MEM).
  function automatic logic [1:0] exe_slot_idx(exe_unit_t u);
    return 2'(u) - 2'd1;
  endfunction

endpackage

// File: rtl/exe_sched_slot.sv
// Per-unit tracking for one long-latency unit: busy flag,
// destination register and the completion hold register.
module exe_sched_slot #(
  parameter int RW = 5,
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [RW-1:0] rd_i,
  input  logic          done_i,
  input  logic [DW-1:0] data_i,
  input  logic          drain_i,
  input  logic          kill_i,
  output logic          busy_o,
  output logic [RW-1:0] rd_o,
  output logic          hold_valid_o,
  output logic [DW-1:0] hold_data_o
);

  logic          busy_q, busy_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          hold_valid_q, hold_valid_d;
  logic [DW-1:0] hold_data_q, hold_data_d;

  always_comb begin
    busy_d       = busy_q;
    rd_d         = rd_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (kill_i) begin
      busy_d       = 1'b0;
      hold_valid_d = 1'b0;
    end else begin
      if (start_i) begin
        busy_d = 1'b1;
        rd_d   = rd_i;
      end
      // A stray completion with nothing outstanding is dropped.
      if (done_i && busy_q) begin
        hold_valid_d = 1'b1;
        hold_data_d  = data_i;
      end
      if (drain_i) begin
        busy_d       = 1'b0;
        hold_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= 1'b0;
      rd_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      rd_q         <= rd_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign busy_o       = busy_q;
  assign rd_o         = rd_q;
  assign hold_valid_o = hold_valid_q;
  assign hold_data_o  = hold_data_q;

endmodule

// File: rtl/exe_unit_scheduler.sv
// Execute-stage issue/writeback controller: scoreboard, unit
// launch and fixed-priority merge onto one registered wb port.
module exe_unit_scheduler
  import drac_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              issue_valid_i,
  input  logic [1:0]        issue_unit_i,
  input  logic [RW-1:0]     issue_rd_i,
  input  logic [RW-1:0]     issue_rs1_i,
  input  logic [RW-1:0]     issue_rs2_i,
  output logic              issue_ready_o,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              mul_start_o,
  output logic              div_start_o,
  output logic              mem_start_o,
  output logic              unit_kill_o,
  input  logic              mul_done_i,
  input  logic              div_done_i,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mul_data_i,
  input  logic [DATA_W-1:0] div_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              wb_valid_o,
  output logic [RW-1:0]     wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              busy_o
);

  logic [2:0]        busy, hold_valid;
  logic [2:0]        start, done, drain;
  logic [RW-1:0]     slot_rd   [3];
  logic [DATA_W-1:0] hold_data [3];
  logic [DATA_W-1:0] done_data [3];

  assign done         = {mem_done_i, div_done_i, mul_done_i};
  assign done_data[0] = mul_data_i;
  assign done_data[1] = div_data_i;
  assign done_data[2] = mem_data_i;

  for (genvar g = 0; g < 3; g++) begin : g_slot
    exe_sched_slot #(
      .RW (RW),
      .DW (DATA_W)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start[g]),
      .rd_i         (issue_rd_i),
      .done_i       (done[g]),
      .data_i       (done_data[g]),
      .drain_i      (drain[g]),
      .kill_i       (kill_i),
      .busy_o       (busy[g]),
      .rd_o         (slot_rd[g]),
      .hold_valid_o (hold_valid[g]),
      .hold_data_o  (hold_data[g])
    );
  end

  exe_unit_t unit;
  logic      pend_rs1, pend_rs2, pend_rd;
  logic      unit_ok, alu_acc;

  assign unit = exe_unit_t'(issue_unit_i);

  always_comb begin
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    pend_rd  = 1'b0;
    for (int u = 0; u < 3; u++) begin
      if (busy[u] && slot_rd[u] == issue_rs1_i) pend_rs1 = 1'b1;
      if (busy[u] && slot_rd[u] == issue_rs2_i) pend_rs2 = 1'b1;
      if (busy[u] && slot_rd[u] == issue_rd_i)  pend_rd  = 1'b1;
    end
    if (issue_rs1_i == '0) pend_rs1 = 1'b0;
    if (issue_rs2_i == '0) pend_rs2 = 1'b0;
    if (issue_rd_i == '0)  pend_rd  = 1'b0;
  end

  // ALU only gets the wb slot when nothing can drain next edge.
  always_comb begin
    unique case (unit)
      UNIT_ALU: unit_ok = ~|hold_valid && ~|done;
      default:  unit_ok = ~busy[exe_slot_idx(unit)];
    endcase
  end

  assign issue_ready_o = issue_valid_i && !kill_i && unit_ok
                      && !pend_rs1 && !pend_rs2 && !pend_rd;

  assign alu_acc     = issue_ready_o && unit == UNIT_ALU;
  assign mul_start_o = issue_ready_o && unit == UNIT_MUL;
  assign div_start_o = issue_ready_o && unit == UNIT_DIV;
  assign mem_start_o = issue_ready_o && unit == UNIT_MEM;
  assign start       = {mem_start_o, div_start_o, mul_start_o};
  assign unit_kill_o = kill_i;

  logic       found;
  logic [1:0] sel;

  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    drain = '0;
    for (int i = 0; i < EXE_NUM_LONG; i++) begin
      if (!found && hold_valid[exe_slot_idx(EXE_DRAIN_PRIO[i])]) begin
        found = 1'b1;
        sel   = exe_slot_idx(EXE_DRAIN_PRIO[i]);
      end
    end
    if (found && !kill_i) drain[sel] = 1'b1;
  end

  exe_sched_wb_t wb_q, wb_d;

  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (!kill_i) begin
      if (found) begin
        wb_d.valid = 1'b1;
        wb_d.rd    = slot_rd[sel];
        wb_d.data  = hold_data[sel];
      end else if (alu_acc) begin
        wb_d.valid = 1'b1;
        wb_d.rd    = issue_rd_i;
        wb_d.data  = alu_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign wb_valid_o = wb_q.valid;
  assign wb_rd_o    = wb_q.rd;
  assign wb_data_o  = wb_q.data;
  assign busy_o     = |busy || |hold_valid;

endmodule

// File: tb/tb_exe_unit_scheduler.sv
// Directed bench for exe_unit_scheduler: ALU vector table plus
// hand-written multi-cycle sequences for the long units.
module tb_exe_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst, kill;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic [63:0] alu_data;
  logic        mul_start, div_start, mem_start, unit_kill;
  logic        mul_done, div_done, mem_done;
  logic [63:0] mul_data, div_data, mem_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exe_unit_scheduler dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .kill_i        (kill),
    .issue_valid_i (issue_valid),
    .issue_unit_i  (issue_unit),
    .issue_rd_i    (issue_rd),
    .issue_rs1_i   (issue_rs1),
    .issue_rs2_i   (issue_rs2),
    .issue_ready_o (issue_ready),
    .alu_data_i    (alu_data),
    .mul_start_o   (mul_start),
    .div_start_o   (div_start),
    .mem_start_o   (mem_start),
    .unit_kill_o   (unit_kill),
    .mul_done_i    (mul_done),
    .div_done_i    (div_done),
    .mem_done_i    (mem_done),
    .mul_data_i    (mul_data),
    .div_data_i    (div_data),
    .mem_data_i    (mem_data),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .busy_o        (busy)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] data;
    logic        exp_ready;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
  } alu_vec_t;

  alu_vec_t vec [8];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_unit  = 2'd0;
    issue_rd    = 5'd0;
    issue_rs1   = 5'd0;
    issue_rs2   = 5'd0;
    alu_data    = '0;
    kill        = 1'b0;
    mul_done    = 1'b0;
    div_done    = 1'b0;
    mem_done    = 1'b0;
  endtask

  task automatic offer(input logic [1:0] u, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] d);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    alu_data    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(string name, logic [4:0] rd, logic [63:0] d);
    chk({name, "_valid"}, 64'(wb_valid), 64'd1);
    chk({name, "_rd"}, 64'(wb_rd), 64'(rd));
    chk({name, "_data"}, wb_data, d);
  endtask

  initial begin
    vec[0] = '{5'd5,  5'd1, 5'd2, 64'h1234, 1'b1, 5'd5, 64'h1234};
    vec[1] = '{5'd6,  5'd5, 5'd5, 64'hdeadbeef, 1'b1, 5'd6, 64'hdeadbeef};
    vec[2] = '{5'd0,  5'd0, 5'd0, 64'h55, 1'b1, 5'd0, 64'h55};
    vec[3] = '{5'd31, 5'd3, 5'd4, 64'hffff_ffff_ffff_ffff, 1'b1, 5'd31,
               64'hffff_ffff_ffff_ffff};
    vec[4] = '{5'd1,  5'd31, 5'd0, 64'h0, 1'b1, 5'd1, 64'h0};
    vec[5] = '{5'd17, 5'd6, 5'd1, 64'h8000_0000_0000_0000, 1'b1, 5'd17,
               64'h8000_0000_0000_0000};
    vec[6] = '{5'd5,  5'd17, 5'd9, 64'ha5a5, 1'b1, 5'd5, 64'ha5a5};
    vec[7] = '{5'd9,  5'd2, 5'd3, 64'h1, 1'b1, 5'd9, 64'h1};

    idle();
    mul_data = '0;
    div_data = '0;
    mem_data = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd0);
    rst = 1'b0;
    tick();

    // back-to-back ALU ops
    for (int i = 0; i < 8; i++) begin
      offer(2'd0, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].data);
      #1;
      chk($sformatf("alu%0d_ready", i), 64'(issue_ready),
          64'(vec[i].exp_ready));
      tick();
      chk_wb($sformatf("alu%0d_wb", i), vec[i].exp_rd, vec[i].exp_data);
    end
    idle();
    tick();
    chk("idle_wb_valid", 64'(wb_valid), 64'd0);
    chk("idle_wb_rd_hold", 64'(wb_rd), 64'd9);
    chk("idle_wb_data_hold", wb_data, 64'h1);

    // MUL rd=7, done three cycles later, dependent ALU stalls
    offer(2'd1, 5'd7, 5'd0, 5'd0, 64'h0);
    #1;
    chk("mul_ready", 64'(issue_ready), 64'd1);
    chk("mul_start", 64'(mul_start), 64'd1);
    chk("mul_div_start", 64'(div_start), 64'd0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      offer(2'd0, 5'd8, 5'd7, 5'd0, 64'h77);
      mul_done = (c == 3);
      mul_data = 64'h2a;
      #1;
      chk($sformatf("raw_stall%0d", c), 64'(issue_ready), 64'd0);
      chk($sformatf("raw_nostart%0d", c), 64'(mul_start), 64'd0);
      tick();
    end
    mul_done = 1'b0;
    #1;
    chk("mul_hold_stall", 64'(issue_ready), 64'd0);
    chk("mul_hold_busy", 64'(busy), 64'd1);
    chk("mul_hold_wbv", 64'(wb_valid), 64'd0);
    tick();
    chk_wb("mul_wb", 5'd7, 64'h2a);
    #1;
    chk("raw_release", 64'(issue_ready), 64'd1);
    tick();
    chk_wb("raw_alu_wb", 5'd8, 64'h77);
    idle();

    // three completions in one cycle drain MEM, MUL, DIV
    offer(2'd1, 5'd10, 5'd0, 5'd0, 64'h0);
    tick();
    offer(2'd2, 5'd11, 5'd0, 5'd0, 64'h0);
    #1;
    chk("tri_div_start", 64'(div_start), 64'd1);
    tick();
    offer(2'd3, 5'd12, 5'd0, 5'd0, 64'h0);
    #1;
    chk("tri_mem_start", 64'(mem_start), 64'd1);
    tick();
    offer(2'd0, 5'd13, 5'd0, 5'd0, 64'hd);
    mul_done = 1'b1;
    div_done = 1'b1;
    mem_done = 1'b1;
    mul_data = 64'h100;
    div_data = 64'h200;
    mem_data = 64'h300;
    #1;
    chk("tri_done_stall", 64'(issue_ready), 64'd0);
    tick();
    mul_done = 1'b0;
    div_done = 1'b0;
    mem_done = 1'b0;
    #1;
    chk("tri_hold_stall", 64'(issue_ready), 64'd0);
    chk("tri_hold_wbv", 64'(wb_valid), 64'd0);
    tick();
    chk_wb("tri_wb_mem", 5'd12, 64'h300);
    chk("tri_stall2", 64'(issue_ready), 64'd0);
    tick();
    chk_wb("tri_wb_mul", 5'd10, 64'h100);
    chk("tri_stall3", 64'(issue_ready), 64'd0);
    tick();
    chk_wb("tri_wb_div", 5'd11, 64'h200);
    chk("tri_alu_ready", 64'(issue_ready), 64'd1);
    tick();
    chk_wb("tri_wb_alu", 5'd13, 64'hd);
    idle();
    tick();
    chk("tri_busy_clear", 64'(busy), 64'd0);

    // structural hazard on DIV
    offer(2'd2, 5'd14, 5'd0, 5'd0, 64'h0);
    tick();
    offer(2'd2, 5'd15, 5'd0, 5'd0, 64'h0);
    #1;
    chk("div2_ready", 64'(issue_ready), 64'd0);
    chk("div2_nostart", 64'(div_start), 64'd0);
    tick();
    div_done = 1'b1;
    div_data = 64'h14;
    #1;
    chk("div2_ready_done", 64'(issue_ready), 64'd0);
    tick();
    div_done = 1'b0;
    #1;
    chk("div2_ready_hold", 64'(issue_ready), 64'd0);
    tick();
    chk_wb("div1_wb", 5'd14, 64'h14);
    chk("div2_ready_go", 64'(issue_ready), 64'd1);
    chk("div2_start_go", 64'(div_start), 64'd1);
    tick();
    idle();
    div_done = 1'b1;
    div_data = 64'h15;
    tick();
    div_done = 1'b0;
    tick();
    chk_wb("div2_wb", 5'd15, 64'h15);

    // WAW on rd=3
    offer(2'd1, 5'd3, 5'd0, 5'd0, 64'h0);
    tick();
    offer(2'd0, 5'd3, 5'd0, 5'd0, 64'h33);
    #1;
    chk("waw_stall", 64'(issue_ready), 64'd0);
    tick();
    mul_done = 1'b1;
    mul_data = 64'h3;
    tick();
    mul_done = 1'b0;
    #1;
    chk("waw_stall_hold", 64'(issue_ready), 64'd0);
    tick();
    chk_wb("waw_mul_wb", 5'd3, 64'h3);
    chk("waw_release", 64'(issue_ready), 64'd1);
    tick();
    chk_wb("waw_alu_wb", 5'd3, 64'h33);
    idle();

    // kill with MUL busy and DIV hold valid
    offer(2'd1, 5'd20, 5'd0, 5'd0, 64'h0);
    tick();
    offer(2'd2, 5'd21, 5'd0, 5'd0, 64'h0);
    tick();
    idle();
    div_done = 1'b1;
    div_data = 64'h21;
    tick();
    div_done = 1'b0;
    kill = 1'b1;
    offer(2'd0, 5'd22, 5'd0, 5'd0, 64'h22);
    #1;
    chk("kill_unit_kill", 64'(unit_kill), 64'd1);
    chk("kill_ready", 64'(issue_ready), 64'd0);
    chk("kill_busy_before", 64'(busy), 64'd1);
    tick();
    chk("kill_busy_after", 64'(busy), 64'd0);
    chk("kill_wbv_after", 64'(wb_valid), 64'd0);
    idle();
    mul_done = 1'b1;
    mul_data = 64'h99;
    #1;
    chk("kill_unit_kill_off", 64'(unit_kill), 64'd0);
    tick();
    mul_done = 1'b0;
    chk("stray_done_wbv", 64'(wb_valid), 64'd0);
    chk("stray_done_busy", 64'(busy), 64'd0);
    tick();
    chk("stray_done_wbv2", 64'(wb_valid), 64'd0);

    // reset mid-operation with MEM busy
    offer(2'd0, 5'd23, 5'd0, 5'd0, 64'h5a5a);
    tick();
    offer(2'd3, 5'd22, 5'd0, 5'd0, 64'h0);
    tick();
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    idle();
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_wbv", 64'(wb_valid), 64'd0);
    chk("rst_mid_wbrd", 64'(wb_rd), 64'd0);
    chk("rst_mid_wbdata", wb_data, 64'd0);
    chk("rst_mid_start", 64'(mem_start), 64'd0);
    chk("rst_mid_ready", 64'(issue_ready), 64'd0);
    rst = 1'b0;
    tick();

    // x0 is never pending
    offer(2'd1, 5'd0, 5'd0, 5'd0, 64'h0);
    #1;
    chk("x0_mul_ready", 64'(issue_ready), 64'd1);
    tick();
    offer(2'd0, 5'd0, 5'd0, 5'd0, 64'habc);
    #1;
    chk("x0_alu_ready", 64'(issue_ready), 64'd1);
    tick();
    chk_wb("x0_alu_wb", 5'd0, 64'habc);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
